// File: rtl/sample_byte_serializer.sv
// ---------------------------------------------------------------------------
// sample_byte_serializer
//
// Purpose:
//   Bridges the show-ahead sample FIFO read side to the FX2 byte interface,
//   running entirely in the fx2_clk domain. Each popped SAMPLE_WIDTH-bit
//   timetag record is sent as NBYTES bytes, least-significant byte first,
//   over a ready/ack handshake. A new record can be popped on the same edge
//   that the final byte of the previous one is accepted, so back-to-back
//   records stream with data_rdy held continuously high.
//
// Optional feature:
//   SERIALIZER_CHECKSUM_EN - when defined, every record is followed by one
//   extra byte holding the XOR of its NBYTES data bytes.
//
// Ports:
//   clk         byte-side clock (fx2_clk)
//   reset_n     asynchronous active-low reset
//   sample_rdy  FIFO non-empty; sample is valid while high
//   sample      FIFO head word
//   sample_ack  one-cycle pop strobe to the FIFO rdreq
//   data_rdy    current byte valid toward the host interface
//   data        current byte
//   data_ack    host accepted the current byte
//   busy        a record is in flight
// ---------------------------------------------------------------------------
module sample_byte_serializer #(
    parameter int SAMPLE_WIDTH = 48,
    parameter int NBYTES       = SAMPLE_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    sample_rdy,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    output logic                    sample_ack,
    output logic                    data_rdy,
    output logic [7:0]              data,
    input  logic                    data_ack,
    output logic                    busy
);

`ifdef SERIALIZER_CHECKSUM_EN
    localparam int LAST_BYTE = NBYTES;
`else
    localparam int LAST_BYTE = NBYTES - 1;
`endif
    localparam int IDX_W = (LAST_BYTE > 0) ? $clog2(LAST_BYTE + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST_BYTE);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [SAMPLE_WIDTH-1:0] shreg_q;
    logic [SAMPLE_WIDTH-1:0] shreg_d;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        idx_d;
    logic                    pop;
    logic                    xfer;

`ifdef SERIALIZER_CHECKSUM_EN
    localparam logic [IDX_W-1:0] CSUM_IDX = IDX_W'(NBYTES);
    logic [7:0] csum_q;
    logic [7:0] csum_d;
`endif

    // A byte moves whenever the host acknowledges while we are presenting
    // one; an ack seen in IDLE has no effect because xfer stays low.
    assign xfer     = (state_q == SEND) && data_ack;
    assign data_rdy = (state_q == SEND);
    assign busy     = (state_q == SEND);

    // The pop strobe is gated by reset_n so the FIFO is never drained while
    // the block is held in reset, even though sample_rdy may be high.
    assign sample_ack = pop && reset_n;

    // The checksum byte is presented once all data bytes have gone out; the
    // shift register is left untouched on the final transfer so data keeps
    // showing the last byte while idle.
`ifdef SERIALIZER_CHECKSUM_EN
    assign data = (idx_q == CSUM_IDX) ? csum_q : shreg_q[7:0];
`else
    assign data = shreg_q[7:0];
`endif

    // State register, shift register and byte index. Everything returns to
    // zero asynchronously so data_rdy drops the moment reset_n goes low and
    // any partially sent record is simply forgotten.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
`ifdef SERIALIZER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
`ifdef SERIALIZER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Next-state logic. A record is captured either from IDLE as soon as the
    // FIFO shows data, or on the edge that accepts the final byte of the
    // current record, which is what keeps back-to-back records gap-free.
    // Intermediate transfers shift the next byte down into bits [7:0].
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        pop     = 1'b0;
`ifdef SERIALIZER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (sample_rdy) begin
                    pop     = 1'b1;
                    shreg_d = sample;
                    idx_d   = '0;
                    state_d = SEND;
`ifdef SERIALIZER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            SEND: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        if (sample_rdy) begin
                            pop     = 1'b1;
                            shreg_d = sample;
                            idx_d   = '0;
`ifdef SERIALIZER_CHECKSUM_EN
                            csum_d  = '0;
`endif
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        shreg_d = shreg_q >> 8;
                        idx_d   = idx_q + IDX_W'(1);
`ifdef SERIALIZER_CHECKSUM_EN
                        csum_d  = csum_q ^ shreg_q[7:0];
`endif
                    end
                end
            end
        endcase
    end

endmodule
